// File: rtl/key_debounce_bank.sv
// Conditions N raw board inputs: synchronise, normalise polarity, debounce, and
// emit press/release/auto-repeat pulses plus sticky pending bits for polling.
module key_debounce_bank #(
    parameter int N_CH         = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] state_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o,
    output logic [N_CH-1:0] pending_o,
    input  logic [N_CH-1:0] clr_i
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [N_CH-1:0] IDLE    = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_CH-1:0] sync_p0;
    logic [N_CH-1:0] sync_p1;
    logic [N_CH-1:0] s_p1;
    logic [N_CH-1:0] flip;
    logic [DB_W-1:0] db_cnt [N_CH];

    // Stage 0/1: two-flop synchroniser, parked at the idle level in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= IDLE;
            sync_p1 <= IDLE;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    assign s_p1 = sync_p1 ^ IDLE;

    always_comb begin
        flip = '0;
        for (int i = 0; i < N_CH; i++) begin
            flip[i] = (s_p1[i] != state_o[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    // Stage 2: debounce counters, debounced level, edge pulses and pending bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_o   <= '0;
            press_o   <= '0;
            release_o <= '0;
            pending_o <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if ((s_p1[i] == state_o[i]) || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
            state_o   <= state_o ^ flip;
            press_o   <= flip & s_p1;
            release_o <= flip & ~s_p1;
            pending_o <= (flip & s_p1) | (pending_o & ~clr_i);
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_rpt
            localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RPT_W   = $clog2(RPT_MAX + 1);
            localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
            localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

            logic [RPT_W-1:0] rpt_cnt [N_CH];
            logic [N_CH-1:0]  rpt_after_first;
            logic [N_CH-1:0]  rpt_tick;

            always_comb begin
                rpt_tick = '0;
                for (int i = 0; i < N_CH; i++) begin
                    rpt_tick[i] = state_o[i] &&
                                  (rpt_after_first[i] ? (rpt_cnt[i] == RATE_LAST)
                                                      : (rpt_cnt[i] == DELAY_LAST));
                end
            end

            // Ticks landing while a release is being debounced are swallowed,
            // so no repeat escapes once the key has physically let go.
            always_ff @(posedge clk) begin
                if (reset) begin
                    repeat_o        <= '0;
                    rpt_after_first <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        rpt_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (!state_o[i] || flip[i]) begin
                            rpt_cnt[i]         <= '0;
                            rpt_after_first[i] <= 1'b0;
                        end else if (rpt_tick[i]) begin
                            rpt_cnt[i]         <= '0;
                            rpt_after_first[i] <= 1'b1;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + RPT_ONE;
                        end
                    end
                    repeat_o <= rpt_tick & ~(s_p1 ^ state_o);
                end
            end
        end else begin : g_no_rpt
            assign repeat_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank: scenarios push cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_key_debounce_bank;
    localparam int N_CH = 4;
    localparam int SEL_ST = 0, SEL_PR = 1, SEL_RL = 2, SEL_RP = 3, SEL_PD = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] clr_i;
    logic [N_CH-1:0] state_o, press_o, release_o, repeat_o, pending_o;

    key_debounce_bank #(
        .N_CH(4), .ACTIVE_LOW(1), .DEBOUNCE_CYC(4),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .state_o(state_o), .press_o(press_o), .release_o(release_o),
        .repeat_o(repeat_o), .pending_o(pending_o), .clr_i(clr_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int         cyc;
        int         scen;
        int         sel;
        logic [3:0] exp;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string sel_name(input int s);
        case (s)
            SEL_ST:  return "state";
            SEL_PR:  return "press";
            SEL_RL:  return "release";
            SEL_RP:  return "repeat";
            default: return "pending";
        endcase
    endfunction

    task automatic expect_at(input int c, input int scen, input int sel, input logic [3:0] v);
        exp_t e;
        e.cyc  = c;
        e.scen = scen;
        e.sel  = sel;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic expect_all(input int c, input int scen, input logic [3:0] st, input logic [3:0] pr,
                              input logic [3:0] rl, input logic [3:0] rp, input logic [3:0] pd);
        expect_at(c, scen, SEL_ST, st);
        expect_at(c, scen, SEL_PR, pr);
        expect_at(c, scen, SEL_RL, rl);
        expect_at(c, scen, SEL_RP, rp);
        expect_at(c, scen, SEL_PD, pd);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].cyc == cyc) begin
                logic [3:0] got;
                case (sbq[k].sel)
                    SEL_ST:  got = state_o;
                    SEL_PR:  got = press_o;
                    SEL_RL:  got = release_o;
                    SEL_RP:  got = repeat_o;
                    default: got = pending_o;
                endcase
                check($sformatf("s%0d_%s@%0d", sbq[k].scen, sel_name(sbq[k].sel), cyc),
                      {28'd0, got}, {28'd0, sbq[k].exp});
                sbq.delete(k);
            end
        end
    end

    initial begin
        int b;
        int r;
        reset  = 1'b1;
        raw_in = 4'hF;
        clr_i  = 4'h0;
        for (int c = 1; c <= 5; c++) expect_all(c, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(2);
        reset = 1'b0;
        step(3);

        // Press ch0, hold through repeats, release after edge 22
        b = cyc;
        raw_in[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            expect_all(b + k, 1,
                       {3'b0, (k >= 6 && k < 28)},
                       {3'b0, (k == 6)},
                       {3'b0, (k == 28)},
                       {3'b0, (k == 16 || k == 19 || k == 22)},
                       {3'b0, (k >= 6)});
        end
        step(22);
        raw_in[0] = 1'b1;
        step(8);
        clr_i = 4'h1;
        expect_at(cyc + 1, 1, SEL_PD, 4'h0);
        step(1);
        clr_i = 4'h0;
        step(2);

        // ch1 glitch of 3 cycles is ignored
        b = cyc;
        raw_in[1] = 1'b0;
        for (int k = 1; k <= 10; k++) expect_all(b + k, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(3);
        raw_in[1] = 1'b1;
        step(7);

        // ch1 low for exactly 4 cycles is accepted, then released
        b = cyc;
        raw_in[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            expect_all(b + k, 2,
                       (k >= 6 && k < 10) ? 4'h2 : 4'h0,
                       (k == 6) ? 4'h2 : 4'h0,
                       (k == 10) ? 4'h2 : 4'h0,
                       4'h0,
                       (k >= 6) ? 4'h2 : 4'h0);
        end
        step(4);
        raw_in[1] = 1'b1;
        step(8);
        clr_i = 4'h2;
        expect_at(cyc + 1, 2, SEL_PD, 4'h0);
        step(1);
        clr_i = 4'h0;
        step(1);

        // ch2 pending: clear, re-press with coincident clear, then clear alone
        b = cyc;
        raw_in[2] = 1'b0;
        expect_at(b + 6, 4, SEL_PR, 4'h4);
        for (int k = 6; k <= 8; k++) expect_at(b + k, 4, SEL_PD, 4'h4);
        step(6);
        raw_in[2] = 1'b1;
        step(2);
        clr_i = 4'h4;
        expect_at(b + 9, 4, SEL_PD, 4'h0);
        step(1);
        clr_i = 4'h0;
        expect_at(b + 12, 4, SEL_RL, 4'h4);
        expect_at(b + 12, 4, SEL_ST, 4'h0);
        for (int k = 10; k <= 12; k++) expect_at(b + k, 4, SEL_PD, 4'h0);
        step(3);
        b = cyc;
        raw_in[2] = 1'b0;
        expect_at(b + 6, 4, SEL_PR, 4'h4);
        expect_at(b + 6, 4, SEL_PD, 4'h4);
        expect_at(b + 7, 4, SEL_PD, 4'h0);
        step(5);
        clr_i = 4'h4;
        step(1);
        step(1);
        clr_i = 4'h0;
        raw_in[2] = 1'b1;
        expect_at(b + 13, 4, SEL_RL, 4'h4);
        for (int k = 8; k <= 13; k++) expect_at(b + k, 4, SEL_PD, 4'h0);
        step(7);

        // ch3 held across a 2-cycle reset: no release, fresh press afterwards
        b = cyc;
        raw_in[3] = 1'b0;
        expect_at(b + 6, 5, SEL_PR, 4'h8);
        for (int k = 6; k <= 8; k++) expect_at(b + k, 5, SEL_ST, 4'h8);
        step(8);
        reset = 1'b1;
        expect_all(b + 9, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_all(b + 10, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        step(2);
        reset = 1'b0;
        r = cyc;
        for (int k = 1; k <= 8; k++) begin
            expect_all(r + k, 5,
                       (k >= 6) ? 4'h8 : 4'h0,
                       (k == 6) ? 4'h8 : 4'h0,
                       4'h0, 4'h0,
                       (k >= 6) ? 4'h8 : 4'h0);
        end
        step(7);
        raw_in[3] = 1'b1;
        expect_at(r + 12, 5, SEL_ST, 4'h8);
        expect_at(r + 13, 5, SEL_ST, 4'h0);
        expect_at(r + 13, 5, SEL_RL, 4'h8);
        step(7);
        clr_i = 4'h8;
        expect_at(cyc + 1, 5, SEL_PD, 4'h0);
        step(1);
        clr_i = 4'h0;
        step(1);

        // All channels together
        b = cyc;
        raw_in = 4'h0;
        for (int k = 1; k <= 14; k++) begin
            expect_all(b + k, 6,
                       (k >= 6 && k < 14) ? 4'hF : 4'h0,
                       (k == 6) ? 4'hF : 4'h0,
                       (k == 14) ? 4'hF : 4'h0,
                       4'h0,
                       (k >= 6) ? 4'hF : 4'h0);
        end
        step(8);
        raw_in = 4'hF;
        step(6);
        clr_i = 4'hF;
        expect_at(cyc + 1, 6, SEL_PD, 4'h0);
        step(1);
        clr_i = 4'h0;
        step(3);

        check("sb_drain", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
